// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding, data width and sequencer state encoding
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_4bit_sequencer_if.sv
// rtl/alu_4bit_sequencer_if.sv - preload, command and response handshake bundle
interface alu_4bit_sequencer_if
    import alu_pkg::*;
#(
    parameter int NREGS = 4
);
    localparam int RIDX_W = $clog2(NREGS);

    logic              ld_valid;
    logic [RIDX_W-1:0] ld_idx;
    logic [DATA_W-1:0] ld_data;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [RIDX_W-1:0] cmd_ra;
    logic [RIDX_W-1:0] cmd_rb;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;
    logic [RIDX_W-1:0] cmd_rd;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_carry;
    logic [RIDX_W-1:0] rsp_rd;

    logic              busy;

    modport master (
        output ld_valid, ld_idx, ld_data,
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm, cmd_rd,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_rd, busy
    );

    modport slave (
        input  ld_valid, ld_idx, ld_data,
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm, cmd_rd,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_rd, busy
    );

endinterface

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - combinational 4-bit ALU, results wrap to 4 bits
module alu_4bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    // Single-level op decode; shifts fill with zero, unary ops ignore b.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHL:  y = a << 1;
            OP_SHR:  y = a >> 1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_4bit_sequencer.sv
// rtl/alu_4bit_sequencer.sv - register-addressed command sequencer around one alu_4bit
module alu_4bit_sequencer
    import alu_pkg::*;
#(
    parameter  int NREGS  = 4,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input logic                 clk,
    input logic                 rst,
    alu_4bit_sequencer_if.slave bus
);

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] regs [NREGS];

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic [RIDX_W-1:0] rd_q;

    logic [DATA_W-1:0] alu_y;
    logic [DATA_W:0]   sum_ext;
    logic              carry;
    logic              accept;

    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_carry_q;
    logic [RIDX_W-1:0] rsp_rd_q;

    alu_4bit u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs; one command in flight at a time.
    always_comb begin
        next_state    = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                accept        = bus.cmd_valid;
                if (bus.cmd_valid) next_state = EXEC;
            end
            EXEC: next_state = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Carry/borrow is derived here from the latched operands rather than by the ALU.
    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        carry   = 1'b0;
        if (op_q == OP_ADD)      carry = sum_ext[DATA_W];
        else if (op_q == OP_SUB) carry = (a_q < b_q);
    end

    // Operand latch; the register file is read before any write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
            rd_q <= '0;
        end else if (accept) begin
            a_q  <= regs[bus.cmd_ra];
            b_q  <= bus.cmd_imm_en ? bus.cmd_imm : regs[bus.cmd_rb];
            op_q <= bus.cmd_op;
            rd_q <= bus.cmd_rd;
        end
    end

    // Register file writes: writeback at EXEC->RESP, preload only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == EXEC) begin
            regs[rd_q] <= alu_y;
        end else if (state == IDLE && bus.ld_valid) begin
            regs[bus.ld_idx] <= bus.ld_data;
        end
    end

    // Response capture; held until the consuming handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_rd_q     <= '0;
        end else if (state == EXEC) begin
            rsp_result_q <= alu_y;
            rsp_zero_q   <= (alu_y == '0);
            rsp_carry_q  <= carry;
            rsp_rd_q     <= rd_q;
        end
    end

    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_rd     = rsp_rd_q;

endmodule

// File: tb/tb_alu_4bit_sequencer.sv
// tb/tb_alu_4bit_sequencer.sv - scoreboard bench for alu_4bit_sequencer
module tb_alu_4bit_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_4bit_sequencer_if #(.NREGS(4)) bus ();

    alu_4bit_sequencer #(.NREGS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] res;
        logic       z;
        logic       c;
        logic [1:0] rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_pass  = 0;
    int         n_total = 0;
    int         mregs[4];
    bit         rand_ready = 1'b0;
    logic       ready_req  = 1'b1;
    logic       rnd_ready  = 1'b1;
    bit         stalled    = 1'b0;
    logic [7:0] held       = '0;

    assign bus.rsp_ready = rand_ready ? rnd_ready : ready_req;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: {carry, result} from plain integer arithmetic.
    function automatic logic [4:0] ref_alu(input logic [2:0] op, input int a, input int b);
        int r;
        bit c;
        c = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = (r > 15); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 15 - a;
            3'd6: r = a * 2;
            default: r = a / 2;
        endcase
        r = r & 15;
        return {c, r[3:0]};
    endfunction

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) check("cmd_ready_timeout", {7'd0, bus.cmd_ready}, 8'd1);
    endtask

    task automatic load(input int idx, input int val);
        wait_idle();
        bus.ld_valid = 1'b1;
        bus.ld_idx   = 2'(idx);
        bus.ld_data  = 4'(val);
        mregs[idx]   = val;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input int ra, input int rb, input bit imm_en,
                        input int imm, input int rd, input bit do_ld, input int li, input int lv,
                        input bit expect_rsp);
        int         a;
        int         b;
        logic [4:0] r;
        exp_t       x;
        wait_idle();
        bus.cmd_op     = op;
        bus.cmd_ra     = 2'(ra);
        bus.cmd_rb     = 2'(rb);
        bus.cmd_imm_en = imm_en;
        bus.cmd_imm    = 4'(imm);
        bus.cmd_rd     = 2'(rd);
        bus.cmd_valid  = 1'b1;
        bus.ld_valid   = do_ld;
        bus.ld_idx     = 2'(li);
        bus.ld_data    = 4'(lv);
        a = mregs[ra];
        b = imm_en ? imm : mregs[rb];
        r = ref_alu(op, a, b);
        if (do_ld) mregs[li] = lv;
        if (expect_rsp) begin
            x.res = r[3:0];
            x.z   = (r[3:0] == 4'd0);
            x.c   = r[4];
            x.rd  = 2'(rd);
            sb.push_back(x);
            mregs[rd] = int'(r[3:0]);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.ld_valid  = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each consuming handshake and checks held outputs.
    always @(negedge clk) begin
        if (stalled && bus.rsp_valid)
            check("rsp_hold", {bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_rd}, held);
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {7'd0, bus.rsp_valid}, 8'd0);
            end else begin
                e = sb.pop_front();
                check("rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_rd},
                      {e.res, e.z, e.c, e.rd});
            end
        end
        stalled = bus.rsp_valid && !bus.rsp_ready;
        held    = {bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_rd};
    end

    initial begin
        int guard;
        bus.ld_valid = 0; bus.ld_idx = 0; bus.ld_data = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_ra = 0; bus.cmd_rb = 0;
        bus.cmd_imm_en = 0; bus.cmd_imm = 0; bus.cmd_rd = 0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_zero,
                                bus.rsp_carry, bus.rsp_rd, 1'b0}, 8'b1000_0000);
        check("reset_result", {4'd0, bus.rsp_result}, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: ADD with carry and handshake latency
        load(0, 9);
        load(1, 8);
        send(OP_ADD, 0, 1, 0, 0, 2, 0, 0, 0, 1);
        @(negedge clk);
        check("lat_exec", {6'd0, bus.rsp_valid, bus.busy}, 8'b01);
        @(negedge clk);
        check("lat_resp", {bus.rsp_valid, bus.rsp_carry, 2'd0, bus.rsp_result}, 8'b1100_0001);
        @(negedge clk);
        check("next_accept_ready", {7'd0, bus.cmd_ready}, 8'd1);

        // 2 and 3: SUB borrow, zero flag, immediate, shifts, NOT
        send(OP_SUB, 1, 0, 0, 0, 3, 0, 0, 0, 1);
        send(OP_SUB, 0, 1, 0, 0, 3, 0, 0, 0, 1);
        send(OP_XOR, 0, 0, 0, 0, 3, 0, 0, 0, 1);
        send(OP_OR,  0, 0, 1, 6, 3, 0, 0, 0, 1);
        send(OP_SHL, 0, 1, 0, 0, 3, 0, 0, 0, 1);
        send(OP_SHR, 0, 1, 0, 0, 3, 0, 0, 0, 1);
        send(OP_NOT, 0, 1, 0, 0, 3, 0, 0, 0, 1);
        send(OP_AND, 0, 1, 0, 0, 3, 0, 0, 0, 1);

        // 4: response back-pressure
        wait_idle();
        @(posedge clk);
        #1 ready_req = 1'b0;
        send(OP_ADD, 2, 3, 0, 0, 1, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_state", {5'd0, bus.rsp_valid, bus.cmd_ready, bus.busy}, 8'b101);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        ready_req     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", {6'd0, bus.cmd_ready, bus.busy}, 8'b10);

        // 6: preload coinciding with accept, then a dropped preload during RESP
        send(OP_ADD, 0, 0, 0, 0, 2, 1, 0, 3, 1);
        send(OP_OR,  0, 0, 1, 0, 2, 0, 0, 0, 1);
        wait_idle();
        @(posedge clk);
        #1 ready_req = 1'b0;
        send(OP_AND, 2, 2, 0, 0, 3, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b1; bus.ld_idx = 2'd1; bus.ld_data = 4'hA;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        ready_req    = 1'b1;
        send(OP_AND, 1, 0, 1, 15, 0, 0, 0, 0, 1);

        // 5: reset during EXEC discards the command
        load(2, 5);
        send(OP_ADD, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        @(negedge clk);
        check("post_reset", {5'd0, bus.rsp_valid, bus.cmd_ready, bus.busy}, 8'b010);
        send(OP_ADD, 2, 0, 1, 0, 1, 0, 0, 0, 1);

        // Randomised traffic with random back-pressure and coincident preloads
        for (int i = 0; i < 4; i++) load(i, int'($urandom_range(0, 15)));
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'b1);
        end
        rand_ready = 1'b0;
        ready_req  = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
